// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants for the two-requester RAM arbiter.
// Holds the default bus widths and the arbiter FSM state encoding.
package ram_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the requester handshake and the RAM port of the
// arbiter.
//   requester side : req0/1, we0/1, addr0/1, wdata0/1 in; done0/1, rdata, busy out
//   RAM side       : ram_rd, ram_wr, ram_addr, ram_d_in out; ram_d_out in
// modport slave is the arbiter view, modport master is the environment view.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d_in;
  logic [DATA_W-1:0] ram_d_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_d_out,
    output done0, done1, rdata, busy, ram_rd, ram_wr, ram_addr, ram_d_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_d_out,
    input  done0, done1, rdata, busy, ram_rd, ram_wr, ram_addr, ram_d_in
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req0_i, req1_i   : requests
//   last_winner_i    : requester granted most recently
//   gnt_valid_o      : at least one request present
//   gnt_o            : index of the granted requester
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_winner_i,
  output logic gnt_valid_o,
  output logic gnt_o
);

  assign gnt_valid_o = req0_i | req1_i;
  // Under contention the requester that did not win last time goes next;
  // otherwise the lone requester wins (req1_i alone selects index 1).
  assign gnt_o = (req0_i & req1_i) ? ~last_winner_i : req1_i;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises single-word accesses from two requesters onto one
// synchronous RAM port with round-robin arbitration.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave (requester handshake + RAM port)
// All outputs are registered.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | waiting for a request; arbitrates and latches cmd
// ST_ISSUE   | one-cycle ram_rd or ram_wr strobe
// ST_CAPTURE | read only: load ram_d_out into rdata
// ST_DONE    | done pulse to the winner; record last winner
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  logic [1:0]        state_q, state_d;
  logic              last_winner_q, last_winner_d;
  logic              winner_q, winner_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_d_in_q, ram_d_in_d;

  logic gnt_valid;
  logic gnt;

  rr_arb2 u_rr_arb2 (
    .req0_i        (bus.req0),
    .req1_i        (bus.req1),
    .last_winner_i (last_winner_q),
    .gnt_valid_o   (gnt_valid),
    .gnt_o         (gnt)
  );

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    winner_d      = winner_q;
    cmd_we_d      = cmd_we_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    rdata_d       = rdata_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    ram_rd_d      = 1'b0;
    ram_wr_d      = 1'b0;
    // RAM address/data simply follow the command registers between grants.
    ram_addr_d    = cmd_addr_q;
    ram_d_in_d    = cmd_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          winner_d    = gnt;
          cmd_we_d    = gnt ? bus.we1    : bus.we0;
          cmd_addr_d  = gnt ? bus.addr1  : bus.addr0;
          cmd_wdata_d = gnt ? bus.wdata1 : bus.wdata0;
          // Strobe is registered together with the state change so it is
          // visible for exactly the ISSUE cycle.
          ram_wr_d    = cmd_we_d;
          ram_rd_d    = ~cmd_we_d;
          ram_addr_d  = cmd_addr_d;
          ram_d_in_d  = cmd_wdata_d;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_we_q) begin
          done0_d = ~winner_q;
          done1_d = winner_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rdata_d = bus.ram_d_out;
        done0_d = ~winner_q;
        done1_d = winner_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_winner_d = winner_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_winner_q <= 1'b1;
      winner_q      <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_d_in_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      winner_q      <= winner_d;
      cmd_we_q      <= cmd_we_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      ram_rd_q      <= ram_rd_d;
      ram_wr_q      <= ram_wr_d;
      ram_addr_q    <= ram_addr_d;
      ram_d_in_q    <= ram_d_in_d;
    end
  end

  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.ram_rd   = ram_rd_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_d_in = ram_d_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous RAM: read data appears one cycle after ram_rd is sampled.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_d_in;
    if (bus.ram_rd) bus.ram_d_out <= ram[bus.ram_addr];
  end

  int overlap_cnt = 0;
  always @(negedge clk) if (bus.ram_rd && bus.ram_wr) overlap_cnt++;

  int tests = 0;
  int fails = 0;

  // Reference model: expected memory, last winner, last read value and the
  // pending request of each requester.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            ref_valid [0:(1<<AW)-1];
  bit            ref_last;
  logic [DW-1:0] ref_rdata;
  bit            p_req [2];
  bit            p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req0 = p_req[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wdata[0];
    bus.req1 = p_req[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wdata[1];
  endtask

  task automatic set_req(input int n, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_req[n] = 1'b1; p_we[n] = we; p_addr[n] = a; p_wdata[n] = d;
  endtask

  task automatic model_reset();
    ref_last  = 1'b1;
    ref_rdata = '0;
  endtask

  // Called at a negedge with the DUT in IDLE and requests already driven.
  // The next posedge samples the requests.
  task automatic run_txn(input string tag, input bit drop, input bit scramble,
                         output int win, output logic [DW-1:0] rd);
    int            n;
    bit            seen;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    win = (p_req[0] && p_req[1]) ? int'(!ref_last) : (p_req[1] ? 1 : 0);
    we  = p_we[win];
    a   = p_addr[win];
    d   = p_wdata[win];

    @(negedge clk);
    chk({tag, " ram_wr"}, 32'(bus.ram_wr), 32'(we));
    chk({tag, " ram_rd"}, 32'(bus.ram_rd), 32'(!we));
    chk({tag, " ram_addr"}, 32'(bus.ram_addr), 32'(a));
    if (we) chk({tag, " ram_d_in"}, 32'(bus.ram_d_in), 32'(d));
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);

    // Inputs are ignored outside IDLE: disturb the winner's fields.
    if (scramble) begin
      if (win == 0) begin bus.addr0 = AW'($urandom); bus.wdata0 = DW'($urandom); bus.we0 = ~we; end
      else          begin bus.addr1 = AW'($urandom); bus.wdata1 = DW'($urandom); bus.we1 = ~we; end
    end

    n = 1;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      chk({tag, " strobes low"}, 32'(bus.ram_rd | bus.ram_wr), 32'd0);
      seen = bus.done0 | bus.done1;
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(n), we ? 32'd2 : 32'd3);
    chk({tag, " done0"}, 32'(bus.done0), 32'(win == 0));
    chk({tag, " done1"}, 32'(bus.done1), 32'(win == 1));
    rd = bus.rdata;
    if (we) begin
      chk({tag, " rdata held"}, 32'(bus.rdata), 32'(ref_rdata));
      ref_mem[a]   = d;
      ref_valid[a] = 1'b1;
    end else begin
      chk({tag, " rdata"}, 32'(bus.rdata), 32'(ref_mem[a]));
      ref_rdata = ref_mem[a];
    end
    ref_last = win[0];

    if (drop) p_req[win] = 1'b0;
    drive();
    @(negedge clk);
    chk({tag, " done cleared"}, 32'(bus.done0 | bus.done1), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            w;
    logic [DW-1:0] r;
    for (int i = 0; i < (1 << AW); i++) begin ref_mem[i] = '0; ref_valid[i] = 1'b0; end
    for (int i = 0; i < 2; i++) begin p_req[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; end
    drive();
    model_reset();

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst strobes", 32'({bus.ram_rd, bus.ram_wr}), 32'd0);
    chk("rst done", 32'({bus.done0, bus.done1}), 32'd0);
    chk("rst rdata", 32'(bus.rdata), 32'd0);
    chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst ram_d_in", 32'(bus.ram_d_in), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of ISSUE.
    @(negedge clk);
    set_req(0, 1'b1, 8'h33, 8'h5A);
    drive();
    @(posedge clk);
    #2;
    chk("midissue ram_wr", 32'(bus.ram_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("async ram_rd", 32'(bus.ram_rd), 32'd0);
    chk("async done", 32'({bus.done0, bus.done1}), 32'd0);
    chk("async busy", 32'(bus.busy), 32'd0);
    p_req[0] = 1'b0;
    drive();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abandoned no done", 32'({bus.done0, bus.done1}), 32'd0);
    end

    // Single write then read-back by the other requester.
    set_req(0, 1'b1, 8'h10, 8'hA5); drive();
    run_txn("wr10", 1'b1, 1'b0, w, r);
    chk("wr10 winner", 32'(w), 32'd0);
    set_req(1, 1'b0, 8'h10, 8'h00); drive();
    run_txn("rd10", 1'b1, 1'b0, w, r);
    chk("rd10 winner", 32'(w), 32'd1);
    chk("rd10 value", 32'(r), 32'hA5);

    // Boundary values, with rdata held across an intervening write.
    set_req(0, 1'b1, 8'hFF, 8'hFF); drive(); run_txn("wrFF", 1'b1, 1'b0, w, r);
    set_req(1, 1'b1, 8'h00, 8'h00); drive(); run_txn("wr00", 1'b1, 1'b0, w, r);
    set_req(0, 1'b0, 8'hFF, 8'h00); drive(); run_txn("rdFF", 1'b1, 1'b0, w, r);
    chk("rdFF value", 32'(r), 32'hFF);
    set_req(1, 1'b1, 8'h20, 8'h77); drive(); run_txn("wr20", 1'b1, 1'b0, w, r);
    chk("rdata across write", 32'(r), 32'hFF);
    set_req(1, 1'b0, 8'h00, 8'h00); drive(); run_txn("rd00", 1'b1, 1'b0, w, r);
    chk("rd00 value", 32'(r), 32'h00);

    // Continuous contention from reset: grants alternate starting with 0.
    rst_n = 1'b0;
    model_reset();
    set_req(0, 1'b1, 8'h40, 8'h11);
    set_req(1, 1'b1, 8'h41, 8'h22);
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_txn("contend", 1'b0, 1'b0, w, r);
      chk("contend order", 32'(w), 32'(k % 2));
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0; drive();
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_req[n] && ($urandom % 2 == 1)) begin
          logic [AW-1:0] a;
          bit            we;
          a  = ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? AW'(8'hFF) : AW'(8'h00))
                                   : AW'($urandom_range(0, 15));
          we = ($urandom % 2 == 1);
          if (!ref_valid[a]) we = 1'b1;
          set_req(n, we, a, DW'($urandom));
        end
      end
      if (!p_req[0] && !p_req[1]) set_req(0, 1'b1, AW'($urandom_range(0, 15)), DW'($urandom));
      drive();
      run_txn("rand", 1'b1, ($urandom % 2 == 1), w, r);
    end

    chk("rd/wr overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, RAM data width in bits.
REQ-002 Parameter ADDR_W, default 8, RAM address width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 req0 / req1  input  1 each  access request from requester 0 / 1; level, held until matching done.
REQ-006 we0 / we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0 / addr1  input  ADDR_W each  target address; valid while reqN high.
REQ-008 wdata0 / wdata1  input  DATA_W each  write data; valid while reqN high.
REQ-009 done0 / done1  output  1 each  one-cycle pulse: requester N's access complete.
REQ-010 rdata  output  DATA_W  read result; valid in the cycle the matching doneN is high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 ram_rd / ram_wr  output  1 each  RAM read / write strobes.
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_d_in  output  DATA_W  RAM write data.
REQ-015 ram_d_out  input  DATA_W  RAM read data; valid one cycle after ram_rd is sampled.

Function
REQ-016 FSM states: IDLE, ISSUE, CAPTURE, DONE; all outputs registered.
REQ-017 IDLE: no request -> stay; any request -> pick winner, latch winner's we/addr/wdata into command registers, go ISSUE.
REQ-018 Arbitration: single request wins outright; both requesting -> requester other than last_winner wins (round-robin); last_winner resets to 1, so requester 0 wins the first contest.
REQ-019 ISSUE: exactly one cycle of ram_wr (write) or ram_rd (read) with ram_addr/ram_d_in from command registers; write -> DONE, read -> CAPTURE.
REQ-020 CAPTURE: load ram_d_out into rdata; go DONE.
REQ-021 DONE: pulse done of winner for one cycle; update last_winner; go IDLE.
REQ-022 Latency, request sampled in IDLE at edge N: strobe high in cycle N+1; done at N+2 for write, N+3 for read.
REQ-023 ram_rd and ram_wr never high together; both low outside ISSUE.
REQ-024 Request inputs ignored outside IDLE; changes to a losing request's fields have no effect until it wins.
REQ-025 Requester holding req high through its done is re-arbitrated in the next IDLE; under continuous contention grants alternate 0,1,0,1.
REQ-026 rdata holds last read value until the next CAPTURE; unchanged by writes.
REQ-027 Addresses are used unmodified; no wrap or range checking.

Reset
REQ-028 rst_n low forces state IDLE, last_winner 1, done0/done1/ram_rd/ram_wr/busy 0, rdata/ram_addr/ram_d_in/command registers 0, regardless of clock.
REQ-029 Reset mid-access abandons it without done; first post-reset edge with rst_n high is evaluated in IDLE.

Structure
REQ-030 Shared package ram_arb_pkg holds the state enumeration and default DATA_W/ADDR_W constants.
REQ-031 One sub-module rr_arb2: combinational 2-way round-robin pick from req0, req1, last_winner; all sequential logic stays in ram_arbiter.

Verification
REQ-032 Reset: rst_n low mid-ISSUE -> ram_rd/ram_wr/done0/done1/busy drop to 0 immediately, with no clock edge.
REQ-033 Single write: req0 we0=1 addr0=0x10 wdata0=0xA5 -> ram_wr one cycle with ram_addr 0x10 and ram_d_in 0xA5; done0 two cycles after sampling.
REQ-034 Read-back: req1 we1=0 addr1=0x10 against RAM model -> ram_rd one cycle; done1 three cycles after sampling with rdata 0xA5.
REQ-035 Contention: req0 and req1 both held high from reset -> done order 0,1,0,1; ram_rd and ram_wr never overlap.
REQ-036 Boundary: write 0xFF to 0xFF, then 0x00 to 0x00 -> reads return 0xFF and 0x00; rdata unchanged across the intervening write.
